moving_average: RTL and testbench

Downstream smoothing stage for the `generator` sample stream. It accepts signed 24-bit samples with a per-sample strobe and keeps a running sum over the last 2^LOG2_N samples in a circular buffer. For each accepted sample it emits the window average, which is the conditioned input to the later adaptive-filter stages. It is the first registered processing stage after the signal source on the Nexys Video (Artix-7) build.

---
 rtl/afc_pkg.sv | 12 +
 rtl/sample_ring_buffer.sv | 37 +++
 rtl/moving_average.sv | 93 +++++++++
 tb/tb_moving_average.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/afc_pkg.sv
// Shared constants for the adaptive-filter chain: sample width and the
// moving-average FILL/RUN state encoding.
package afc_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } ma_state_t;

endpackage

// File: rtl/sample_ring_buffer.sv
// Purpose: N-entry circular sample store, single port at an internal wrapping pointer.
// Latency: oldest entry read combinationally; write and pointer step on the advance edge.
// Backpressure: none; advance is accepted every cycle it is high.
module sample_ring_buffer
  import afc_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int LOG2_N     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] oldest
);

  logic [DATA_WIDTH-1:0] mem [1 << LOG2_N];
  logic [LOG2_N-1:0]     wr_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (advance) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Contents are left unreset so the array can live in distributed RAM.
  always_ff @(posedge clk) begin
    if (advance) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign oldest = mem[wr_ptr];

endmodule

// File: rtl/moving_average.sv
// Purpose: running average over the last 2^LOG2_N accepted samples (floor division).
// Latency: one cycle from accepted sample to registered data_out/data_out_valid.
// Backpressure: none; a sample is taken on every data_in_valid cycle.
module moving_average
  import afc_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_W,
  parameter int LOG2_N     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  window_full
);

  localparam int              ACC_W     = DATA_WIDTH + LOG2_N;
  localparam logic [LOG2_N:0] LAST_FILL = (LOG2_N + 1)'((1 << LOG2_N) - 1);

  ma_state_t               state_q, state_d;
  logic [LOG2_N:0]         fill_cnt;
  logic signed [ACC_W-1:0] acc, acc_next, sub_term;
  logic [DATA_WIDTH-1:0]   oldest;
  logic                    accept;
  logic                    emit;

  // A sample coinciding with reset is dropped, including its buffer write.
  assign accept = data_in_valid & ~reset;

  sample_ring_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_N     (LOG2_N)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .advance (accept),
    .wr_data (data_in),
    .oldest  (oldest)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sub_term = '0;
    emit     = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (data_in_valid && fill_cnt == LAST_FILL) begin
          state_d = ST_RUN;
          emit    = 1'b1;
        end
      end
      ST_RUN: begin
        sub_term = ACC_W'($signed(oldest));
        emit     = data_in_valid;
      end
      default: state_d = ST_FILL;
    endcase
    acc_next = acc + ACC_W'($signed(data_in)) - sub_term;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc            <= '0;
      fill_cnt       <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      window_full    <= 1'b0;
    end else begin
      data_out_valid <= emit;
      if (data_in_valid) begin
        acc <= acc_next;
        if (state_q == ST_FILL) begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
      if (emit) begin
        data_out    <= DATA_WIDTH'(acc_next >>> LOG2_N);
        window_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moving_average.sv
// Self-checking bench for moving_average: fixed vector table, hand-written corner
// sequences and randomized traffic against a queue-based window model.
module tb_moving_average;

  localparam int DW = 24;
  localparam int L2 = 4;
  localparam int N  = 1 << L2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          window_full;

  moving_average #(.DATA_WIDTH(DW), .LOG2_N(L2)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .window_full    (window_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the accepted samples since reset, averaged once N are present.
  longint        hist[$];
  logic [DW-1:0] m_out;
  logic          m_vld;
  logic          m_full;

  typedef struct {
    logic          rst;
    logic          vld;
    logic [DW-1:0] din;
    logic          exp_vld;
    logic [DW-1:0] exp_out;
    logic          exp_full;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_step(input logic rst, input logic vld, input logic [DW-1:0] din);
    longint sum;
    if (rst) begin
      hist.delete();
      m_out  = '0;
      m_vld  = 1'b0;
      m_full = 1'b0;
    end else if (vld) begin
      hist.push_back(longint'(signed'(din)));
      if (hist.size() > N) void'(hist.pop_front());
      m_vld = 1'b0;
      if (hist.size() == N) begin
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        m_out  = DW'(sum >>> L2);
        m_vld  = 1'b1;
        m_full = 1'b1;
      end
    end else begin
      m_vld = 1'b0;
    end
  endfunction

  // One clock cycle: drive at negedge, update model on the edge, check 1 ns after.
  task automatic cycle(input logic rst, input logic vld, input logic [DW-1:0] din, input string tag);
    @(negedge clk);
    reset         = rst;
    data_in_valid = vld;
    data_in       = din;
    @(posedge clk);
    model_step(rst, vld, din);
    #1;
    chk({tag, "_vld"},  64'(data_out_valid), 64'(m_vld));
    chk({tag, "_full"}, 64'(window_full),    64'(m_full));
    chk({tag, "_out"},  64'(data_out),       64'(m_out));
  endtask

  task automatic fill_const(input int count, input logic [DW-1:0] v, input int gap, input string tag);
    for (int i = 0; i < count; i++) begin
      cycle(1'b0, 1'b1, v, tag);
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, $urandom(), tag);
    end
  endtask

  task automatic ramp_1600(input int gap, input string tag);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b1, 24'd1600, tag);
      chk({tag, "_ramp"}, 64'(data_out), 64'((k < N ? k : N) * 100));
      for (int g = 0; g < gap; g++) begin
        cycle(1'b0, 1'b0, $urandom(), tag);
        chk({tag, "_hold"}, 64'(data_out), 64'((k < N ? k : N) * 100));
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    data_in_valid = 1'b0;
    data_in       = '0;
    model_step(1'b1, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out",  64'(data_out),       64'd0);
    chk("reset_vld",  64'(data_out_valid), 64'd0);
    chk("reset_full", 64'(window_full),    64'd0);

    // Scenario 1 as an explicit vector table.
    tbl.push_back('{1'b1, 1'b0, 24'd0, 1'b0, 24'd0, 1'b0});
    for (int i = 1; i <= N; i++)
      tbl.push_back('{1'b0, 1'b1, 24'd1000, (i == N), (i == N) ? 24'd1000 : 24'd0, (i == N)});
    tbl.push_back('{1'b0, 1'b0, 24'd77, 1'b0, 24'd1000, 1'b1});
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset         = tbl[i].rst;
      data_in_valid = tbl[i].vld;
      data_in       = tbl[i].din;
      @(posedge clk);
      model_step(tbl[i].rst, tbl[i].vld, tbl[i].din);
      #1;
      chk($sformatf("tbl%0d_vld", i),  64'(data_out_valid), 64'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_out", i),  64'(data_out),       64'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_full", i), 64'(window_full),    64'(tbl[i].exp_full));
    end

    // Scenario 2: zero-filled window, then a 1600 step through the pointer wrap.
    cycle(1'b1, 1'b0, '0, "s2");
    fill_const(N, 24'd0, 0, "s2");
    ramp_1600(0, "s2");

    // Scenario 3: floor of negatives and full-scale extremes.
    cycle(1'b1, 1'b0, '0, "s3");
    fill_const(20, 24'hFFFFFF, 0, "s3n");
    chk("s3_minus1", 64'(data_out), 64'h0000_0000_00FF_FFFF);
    fill_const(20, 24'h7FFFFF, 0, "s3p");
    chk("s3_maxpos", 64'(data_out), 64'h0000_0000_007F_FFFF);
    fill_const(20, 24'h800000, 0, "s3m");
    chk("s3_maxneg", 64'(data_out), 64'h0000_0000_0080_0000);
    // A single -1 after zeros must floor to -1, not truncate to 0.
    fill_const(N, 24'd0, 0, "s3z");
    cycle(1'b0, 1'b1, 24'hFFFFFF, "s3f");
    chk("s3_floor", 64'(data_out), 64'h0000_0000_00FF_FFFF);

    // Scenario 4: same step with a sample only every third cycle.
    cycle(1'b1, 1'b0, '0, "s4");
    fill_const(N, 24'd0, 2, "s4");
    ramp_1600(2, "s4");

    // Scenario 5: reset coinciding with a valid sample mid-run.
    fill_const(20, 24'd5000, 0, "s5a");
    cycle(1'b1, 1'b1, 24'd5000, "s5r");
    chk("s5_rst_out",  64'(data_out),    64'd0);
    chk("s5_rst_full", 64'(window_full), 64'd0);
    for (int i = 1; i < N; i++) begin
      cycle(1'b0, 1'b1, 24'd160, "s5b");
      chk("s5_novld", 64'(data_out_valid), 64'd0);
    end
    cycle(1'b0, 1'b1, 24'd160, "s5c");
    chk("s5_first_vld", 64'(data_out_valid), 64'd1);
    chk("s5_first_out", 64'(data_out),       64'd160);

    // Randomized traffic with occasional resets.
    cycle(1'b1, 1'b0, '0, "rnd");
    for (int i = 0; i < 1500; i++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 3))
        0: d = 24'h7FFFFF - 24'($urandom_range(0, 3));
        1: d = 24'h800000 + 24'($urandom_range(0, 3));
        default: d = 24'($urandom());
      endcase
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, d, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
